// File: rtl/coms_pkg.sv
// Shared definitions for the motor-board UART link: status frame layout, CRC16 step function
// and the receive deframer state encoding.
package coms_pkg;

    localparam logic [31:0] STATUS_MAGIC       = 32'h1CEB00DA;
    localparam int unsigned STATUS_FRAME_LEN   = 21;
    localparam int unsigned STATUS_PAYLOAD_LEN = 15;

    // CRC16 x^16+x^15+x^2+1, one byte per call, first serial bit is data[7].
    function automatic logic [15:0] nextCRC16_D8(input logic [7:0] data, input logic [15:0] crc);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h8005;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    localparam logic [15:0] CRC_AFTER_MAGIC =
        nextCRC16_D8(8'hDA, nextCRC16_D8(8'h00, nextCRC16_D8(8'hEB,
        nextCRC16_D8(8'h1C, 16'hFFFF))));

    typedef enum logic [2:0] {
        StHunt,
        StBody,
        StCrcHi,
        StCrcLo,
        StCommit
    } sfd_state_e;

endpackage

// File: rtl/status_frame_decoder_if.sv
// Byte stream from uart_rx into the status deframer.
interface status_frame_decoder_if;
    logic       rx_data_ready;
    logic [7:0] rx_data;

    modport master (output rx_data_ready, output rx_data);
    modport slave  (input rx_data_ready, input rx_data);
endinterface

// File: rtl/crc16_d8.sv
// Registered CRC16 accumulator: loads init_value on init, folds in one byte per enable.
module crc16_d8
    import coms_pkg::*;
(
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        init,
    input  logic [15:0] init_value,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_q;

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            crc_q <= '0;
        end else if (init) begin
            crc_q <= init_value;
        end else if (enable) begin
            crc_q <= nextCRC16_D8(data, crc_q);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/status_frame_decoder.sv
// STATUS frame deframer: hunts the magic number, checks CRC16 and commits per-motor telemetry.
module status_frame_decoder
    import coms_pkg::*;
#(
    parameter int unsigned NUMBER_OF_MOTORS = 6,
    parameter int unsigned TIMEOUT_CYCLES   = 50000
) (
    input  logic                   CLK,
    input  logic                   reset_n,
    status_frame_decoder_if.slave  rx,
    output logic signed [31:0]     position     [NUMBER_OF_MOTORS],
    output logic signed [31:0]     velocity     [NUMBER_OF_MOTORS],
    output logic signed [31:0]     displacement [NUMBER_OF_MOTORS],
    output logic        [15:0]     current      [NUMBER_OF_MOTORS],
    output logic                   frame_valid,
    output logic        [7:0]      frame_motor,
    output logic                   crc_error,
    output logic                   id_error,
    output logic                   timeout_error,
    output logic        [15:0]     good_frame_count,
    output logic        [15:0]     bad_frame_count
);

    localparam int unsigned       TIMER_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]        LAST_BODY = 4'(STATUS_PAYLOAD_LEN - 1);

    sfd_state_e         state_q;
    // Only the three most recent bytes matter; the fourth comes straight from rx_data.
    logic [23:0]        hunt_q;
    logic [3:0]         count_q;
    logic [7:0]         payload_q [STATUS_PAYLOAD_LEN];
    logic [7:0]         crc_hi_q;
    logic               crc_ok_q;
    logic [TIMER_W-1:0] timer_q;

    logic        strobe;
    logic        magic_hit;
    logic        in_frame;
    logic        timed_out;
    logic        crc_en;
    logic [15:0] crc;
    logic        id_in_range;

    assign strobe      = rx.rx_data_ready;
    assign magic_hit   = (state_q == StHunt) && strobe && ({hunt_q, rx.rx_data} == STATUS_MAGIC);
    assign in_frame    = (state_q == StBody) || (state_q == StCrcHi) || (state_q == StCrcLo);
    assign timed_out   = in_frame && (timer_q == TIMER_MAX);
    assign crc_en      = (state_q == StBody) && strobe && !timed_out;
    assign id_in_range = 32'(payload_q[0]) < NUMBER_OF_MOTORS;

    crc16_d8 u_crc (
        .CLK        (CLK),
        .reset_n    (reset_n),
        .init       (magic_hit),
        .init_value (CRC_AFTER_MAGIC),
        .enable     (crc_en),
        .data       (rx.rx_data),
        .crc        (crc)
    );

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q          <= StHunt;
            hunt_q           <= '0;
            count_q          <= '0;
            crc_hi_q         <= '0;
            crc_ok_q         <= 1'b0;
            timer_q          <= '0;
            frame_valid      <= 1'b0;
            frame_motor      <= '0;
            crc_error        <= 1'b0;
            id_error         <= 1'b0;
            timeout_error    <= 1'b0;
            good_frame_count <= '0;
            bad_frame_count  <= '0;
            for (int i = 0; i < int'(STATUS_PAYLOAD_LEN); i++) begin
                payload_q[i] <= '0;
            end
            for (int m = 0; m < int'(NUMBER_OF_MOTORS); m++) begin
                position[m]     <= '0;
                velocity[m]     <= '0;
                displacement[m] <= '0;
                current[m]      <= '0;
            end
        end else begin
            frame_valid   <= 1'b0;
            crc_error     <= 1'b0;
            id_error      <= 1'b0;
            timeout_error <= 1'b0;

            if (timed_out) begin
                // A byte landing on the timeout cycle becomes the first hunt byte.
                timeout_error   <= 1'b1;
                bad_frame_count <= bad_frame_count + 16'd1;
                hunt_q          <= strobe ? {16'h0000, rx.rx_data} : 24'h000000;
                timer_q         <= '0;
                state_q         <= StHunt;
            end else begin
                if (in_frame) begin
                    timer_q <= strobe ? '0 : timer_q + 1'b1;
                end
                unique case (state_q)
                    StHunt: begin
                        if (strobe) begin
                            hunt_q <= {hunt_q[15:0], rx.rx_data};
                        end
                        if (magic_hit) begin
                            count_q <= '0;
                            timer_q <= '0;
                            state_q <= StBody;
                        end
                    end
                    StBody: begin
                        if (strobe) begin
                            payload_q[count_q] <= rx.rx_data;
                            count_q            <= count_q + 4'd1;
                            if (count_q == LAST_BODY) begin
                                state_q <= StCrcHi;
                            end
                        end
                    end
                    StCrcHi: begin
                        if (strobe) begin
                            crc_hi_q <= rx.rx_data;
                            state_q  <= StCrcLo;
                        end
                    end
                    StCrcLo: begin
                        if (strobe) begin
                            crc_ok_q <= ({crc_hi_q, rx.rx_data} == crc);
                            state_q  <= StCommit;
                        end
                    end
                    StCommit: begin
                        if (!crc_ok_q) begin
                            crc_error       <= 1'b1;
                            bad_frame_count <= bad_frame_count + 16'd1;
                        end else if (!id_in_range) begin
                            id_error        <= 1'b1;
                            bad_frame_count <= bad_frame_count + 16'd1;
                        end else begin
                            for (int m = 0; m < int'(NUMBER_OF_MOTORS); m++) begin
                                if (payload_q[0] == 8'(m)) begin
                                    position[m]     <= {payload_q[1], payload_q[2],
                                                        payload_q[3], payload_q[4]};
                                    velocity[m]     <= {payload_q[5], payload_q[6],
                                                        payload_q[7], payload_q[8]};
                                    displacement[m] <= {payload_q[9], payload_q[10],
                                                        payload_q[11], payload_q[12]};
                                    current[m]      <= {payload_q[13], payload_q[14]};
                                end
                            end
                            frame_motor      <= payload_q[0];
                            frame_valid      <= 1'b1;
                            good_frame_count <= good_frame_count + 16'd1;
                        end
                        hunt_q  <= strobe ? {16'h0000, rx.rx_data} : 24'h000000;
                        state_q <= StHunt;
                    end
                    default: state_q <= StHunt;
                endcase
            end
        end
    end

endmodule

// File: doc/status_frame_decoder.md
Name: status_frame_decoder

Overview:
- Receive-side deframer for the motor-board UART link. It sits directly downstream of uart_rx and replaces the inline status matcher in the coms top level.
- Hunts the STATUS frame magic number in the byte stream and accumulates CRC16 incrementally.
- On a valid frame, commits position/velocity/displacement/current for the addressed motor. Bad frames are reported, counted and never committed.

Parameters:
- NUMBER_OF_MOTORS, 6, number of per-motor status slots; valid motor ids are 0..NUMBER_OF_MOTORS-1.
- TIMEOUT_CYCLES, 50000, maximum gap in CLK cycles between bytes inside a frame. Must be >= 1.

Ports:
- CLK  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- rx_data_ready  in  1  single-cycle strobe: rx_data is valid this cycle
- rx_data  in  8  received byte
- position  out  32 x NUMBER_OF_MOTORS  signed, per motor
- velocity  out  32 x NUMBER_OF_MOTORS  signed, per motor
- displacement  out  32 x NUMBER_OF_MOTORS  signed, per motor
- current  out  16 x NUMBER_OF_MOTORS  unsigned, per motor
- frame_valid  out  1  pulse: a frame was committed
- frame_motor  out  8  motor id of the last committed frame
- crc_error  out  1  pulse: frame dropped on CRC mismatch
- id_error  out  1  pulse: CRC ok but motor id out of range; frame dropped
- timeout_error  out  1  pulse: frame abandoned on inter-byte timeout
- good_frame_count  out  16  wrapping count of committed frames
- bad_frame_count  out  16  wrapping count of crc, id and timeout errors

Behaviour:
- Reset (reset_n low at a CLK edge) clears all outputs, arrays, counters, hunt register, byte counter and timer to 0. State goes to HUNT. Reset wins over any same-cycle byte.
- Frame layout, 21 bytes, MSB-first everywhere:
  - bytes 0-3: magic 0x1CEB00DA
  - byte 4: motor id
  - bytes 5-8: position
  - bytes 9-12: velocity
  - bytes 13-16: displacement
  - bytes 17-18: current
  - bytes 19-20: CRC high byte, then low byte
- CRC: polynomial x^16+x^15+x^2+1, init 0xFFFF, covering bytes 0-18 in order, first serial bit D[7]. Same function the TX side uses.
- HUNT state:
  - Each strobed byte shifts into a 32-bit register (new byte enters at the LSB).
  - When {shift[23:0], rx_data} == magic in that strobe cycle, load crc with CRC_AFTER_MAGIC, clear the byte counter, go to BODY.
  - Magic match is checked only in HUNT. Magic bytes appearing inside BODY are payload.
- BODY state:
  - Each strobed byte: store it in the 15-byte payload buffer at the counter position, update crc, increment the counter.
  - After the 15th byte, go to CRC_HI.
- CRC_HI state: the strobed byte is latched as the expected high byte. Go to CRC_LO.
- CRC_LO state: the strobed byte is compared together with the latched high byte; go to COMMIT.
- COMMIT state (one cycle, no byte consumed):
  - CRC match and id < NUMBER_OF_MOTORS: write all four fields of that motor slot, set frame_motor, pulse frame_valid, increment good_frame_count.
  - CRC mismatch: pulse crc_error, increment bad_frame_count.
  - CRC match but id out of range: pulse id_error, increment bad_frame_count.
  - Always clear the hunt register and return to HUNT.
  - A byte strobed during COMMIT is fed to HUNT's shift register, so it is not lost.
- Latency: the final CRC byte is accepted at edge E; arrays and pulses update at edge E+1. Each pulse is exactly 1 cycle. Error pulses are mutually exclusive.
- Timeout:
  - In BODY, CRC_HI and CRC_LO, a timer resets on every strobe and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: pulse timeout_error, increment bad_frame_count, clear the hunt register, go to HUNT.
  - A byte arriving in the same cycle as the timeout is fed to HUNT.
- Other slots are unaffected by a commit. Fields are written whole; there are no partial updates.
- Counters wrap 0xFFFF -> 0x0000.

Decomposition:
- Shared package coms_pkg holds:
  - magic-number and frame-length localparams for all four frame types (shared with the TX path);
  - the nextCRC16_D8 function;
  - CRC_AFTER_MAGIC, a constant computed by that function from 0xFFFF over the status magic;
  - a state enum for this block.
- One sub-module is natural: crc16_d8, a registered accumulator with init, enable, data, and crc out. The TX path reuses it.

Test Plan:
- Valid frame, id=2, pos=0x00000064, vel=0xFFFFFFF6, disp=0x12345678, cur=0x0ABC, correct CRC from the bench model; bytes spaced 434 cycles apart -> one cycle after the last byte: position[2]=100, velocity[2]=-10, displacement[2]=0x12345678, current[2]=0x0ABC, frame_valid=1 for 1 cycle, frame_motor=2, good_frame_count=1, other slots stay 0.
- Same frame with CRC low byte XOR 0x01 -> crc_error pulse, bad_frame_count=1, slot 2 unchanged; a following correct frame commits normally.
- Valid CRC with id=6 -> id_error pulse, no array change, bad_frame_count=1.
- Stream 0x1C 0x1C 0xEB 0x00 0xDA followed by a valid body -> commits (hunt resynchronises on the sliding window). Payload containing 1C EB 00 DA inside a valid frame -> single commit, no restart.
- TIMEOUT_CYCLES=100; send magic plus 5 bytes, idle 100 cycles -> timeout_error pulse; a valid frame afterwards commits.
- reset_n low for 1 cycle mid-BODY after a prior commit -> all outputs and counters 0; the remaining bytes of the interrupted frame commit nothing; the next full frame commits.
